ifx_dig_compute_master: RTL and testbench

// - Requester side of the digital compute interface; drives the compute engine.
// - Takes samples from an upstream source and presents each one on the engine's data_i.
// - Issues one compute request per sample and waits for valid from the engine.
// - Captures each result into a small output FIFO; flags a sticky timeout error if the engine never answers.

---
 rtl/ifx_dig_compute_master.sv | 205 ++++++++++++++++++++
 tb/tb_ifx_dig_compute_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifx_dig_compute_master.sv
// Requester side of the digital compute interface: feeds samples to the engine, collects results in a FIFO.
// Optional result statistics counter enabled by defining IFX_DIG_CMP_STATS_EN.

module ifx_dig_compute_master #(
    parameter int DWIDTH      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [7:0]        num_req_i,
    input  logic [DWIDTH-1:0] smp_data_i,
    input  logic              smp_valid_i,
    output logic              smp_ready_o,
    output logic [DWIDTH-1:0] dut_data_o,
    output logic              dut_req_o,
    input  logic [DWIDTH-1:0] dut_data_i,
    input  logic              dut_valid_i,
    output logic [DWIDTH-1:0] res_data_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_timeout_o
`ifdef IFX_DIG_CMP_STATS_EN
    ,
    output logic [15:0]       res_cnt_o
`endif
);

    // state | meaning
    // IDLE  | waiting for start_i
    // LOAD  | waiting for an upstream sample (only while the FIFO has room)
    // REQ   | one-cycle compute request to the engine
    // WAIT  | waiting for engine valid, timeout running
    // DONE  | one-cycle end-of-batch pulse

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        cnt_q;
    logic [TW-1:0]     tmo_q;
    logic              err_q;
    logic              zdone_q;
    logic [DWIDTH-1:0] dut_data_q;

    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic              ld_cnt;
    logic              accept;
    logic              set_err;
    logic              clr_err;
    logic              zdone_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && res_ready_i;

    always_comb begin
        state_d     = state_q;
        smp_ready_o = 1'b0;
        dut_req_o   = 1'b0;
        push        = 1'b0;
        ld_cnt      = 1'b0;
        accept      = 1'b0;
        set_err     = 1'b0;
        clr_err     = 1'b0;
        zdone_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    clr_err = 1'b1;
                    if (num_req_i != 8'd0) begin
                        ld_cnt  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                smp_ready_o = !fifo_full;
                if (smp_valid_i && !fifo_full) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                dut_req_o = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A valid arriving in the final timeout cycle still wins.
                if (dut_valid_i) begin
                    push    = 1'b1;
                    state_d = (cnt_q == 8'd1) ? ST_DONE : ST_LOAD;
                end else if (tmo_q == '0) begin
                    set_err = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE) || zdone_q;
    assign err_timeout_o = err_q;
    assign dut_data_o    = dut_data_q;
    assign res_valid_o   = !fifo_empty;
    assign res_data_o    = fifo_empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    // rstn_i is active-high despite its name.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            zdone_q    <= 1'b0;
            dut_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            zdone_q <= zdone_d;

            if (ld_cnt) begin
                cnt_q <= num_req_i;
            end else if (push) begin
                cnt_q <= cnt_q - 8'd1;
            end

            // Down-counter: remaining WAIT cycles before abort.
            if (state_q == ST_REQ) begin
                tmo_q <= TMO_LOAD;
            end else if (state_q == ST_WAIT && tmo_q != '0) begin
                tmo_q <= tmo_q - TW'(1);
            end

            if (clr_err) begin
                err_q <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end

            if (accept) begin
                dut_data_q <= smp_data_i;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= dut_data_i;
        end
    end

`ifdef IFX_DIG_CMP_STATS_EN
    logic [15:0] res_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            res_cnt_q <= 16'd0;
        end else if (push && res_cnt_q != 16'hFFFF) begin
            res_cnt_q <= res_cnt_q + 16'd1;
        end
    end

    assign res_cnt_o = res_cnt_q;
`endif

endmodule

// File: tb/tb_ifx_dig_compute_master.sv
// Bench for ifx_dig_compute_master: directed scenarios plus randomized batches against a queue-based result model.
// Build with IFX_DIG_CMP_STATS_EN defined to also check the push counter.

module tb_ifx_dig_compute_master;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int T     = 64;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [7:0]    num_req_i = 8'd0;
    logic [DW-1:0] smp_data_i = '0;
    logic          smp_valid_i = 1'b0;
    logic          smp_ready_o;
    logic [DW-1:0] dut_data_o;
    logic          dut_req_o;
    logic [DW-1:0] dut_data_i = '0;
    logic          dut_valid_i = 1'b0;
    logic [DW-1:0] res_data_o;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          err_timeout_o;
`ifdef IFX_DIG_CMP_STATS_EN
    logic [15:0]   res_cnt_o;
`endif

    always #5 clk = ~clk;

    ifx_dig_compute_master #(
        .DWIDTH      (DW),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rst_i),
        .start_i       (start_i),
        .num_req_i     (num_req_i),
        .smp_data_i    (smp_data_i),
        .smp_valid_i   (smp_valid_i),
        .smp_ready_o   (smp_ready_o),
        .dut_data_o    (dut_data_o),
        .dut_req_o     (dut_req_o),
        .dut_data_i    (dut_data_i),
        .dut_valid_i   (dut_valid_i),
        .res_data_o    (res_data_o),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_timeout_o (err_timeout_o)
`ifdef IFX_DIG_CMP_STATS_EN
        ,
        .res_cnt_o     (res_cnt_o)
`endif
    );

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    int            pushes = 0;
    int            consumed = 0;
    int            req_seen = 0;
    int            req_exp = 0;
    bit            rdy_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Result sink: random backpressure, in-order compare against the model queue.
    always @(negedge clk) begin
        res_ready_i = rdy_en && ($urandom_range(0, 3) != 0);
        if (res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) chk("pop_empty", exp_q.size(), 1);
            else                   chk("res_data", res_data_o, exp_q.pop_front());
        end
        if (dut_req_o) req_seen++;
    end

    // lat_mode: 0 mixed random, 1 -> 1 cycle, 2 -> last WAIT cycle, 3 -> 3 cycles
    task automatic run_batch(input int n, input int silent_idx, input int rst_idx,
                             input int lat_mode, input int s_fix, input int r_fix);
        logic [DW-1:0] s;
        logic [DW-1:0] r;
        int            k;
        int            lat;
        int            early;
        @(posedge clk); #1;
        start_i   = 1'b1;
        num_req_i = n[7:0];
        @(posedge clk); #1;
        start_i   = 1'b0;
        @(negedge clk);
        chk("start_err_clr", err_timeout_o, 0);
        if (n == 0) begin
            chk("zero_done", done_o, 1);
            chk("zero_busy", busy_o, 0);
            @(negedge clk);
            chk("zero_done_1cyc", done_o, 0);
            return;
        end
        chk("start_busy", busy_o, 1);
        for (int i = 0; i < n; i++) begin
            s = (s_fix >= 0) ? s_fix[DW-1:0] : DW'($urandom);
            repeat (1 + $urandom_range(0, 2)) @(posedge clk);
            #1;
            smp_data_i  = s;
            smp_valid_i = 1'b1;
            for (k = 0; k < 300; k++) begin
                @(negedge clk);
                if (smp_ready_o) break;
            end
            if (k == 300) begin
                chk("smp_wait_budget", k, 0);
                smp_valid_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
            smp_valid_i = 1'b0;
            consumed++;
            @(negedge clk);
            chk("req", dut_req_o, 1);
            chk("req_data", dut_data_o, s);
            req_exp++;
            if (i == rst_idx) begin
                @(posedge clk); #1;
                rst_i = 1'b1;
                @(posedge clk); #1;
                rst_i = 1'b0;
                exp_q.delete();
                pushes = 0;
                @(negedge clk);
                chk("rst_busy", busy_o, 0);
                chk("rst_res_valid", res_valid_o, 0);
                chk("rst_req", dut_req_o, 0);
                return;
            end
            if (i == silent_idx) begin
                early = 0;
                for (int c = 0; c < T; c++) begin
                    @(negedge clk);
                    if (err_timeout_o || done_o) early++;
                end
                chk("tmo_early", early, 0);
                @(negedge clk);
                chk("tmo_err", err_timeout_o, 1);
                chk("tmo_done", done_o, 1);
                @(negedge clk);
                chk("tmo_idle", busy_o, 0);
                chk("tmo_sticky", err_timeout_o, 1);
                return;
            end
            case (lat_mode)
                1: lat = 1;
                2: lat = T;
                3: lat = 3;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       lat = 1;
                        1:       lat = T;
                        default: lat = $urandom_range(1, T);
                    endcase
                end
            endcase
            r = (r_fix >= 0) ? r_fix[DW-1:0] : DW'($urandom);
            repeat (lat) @(posedge clk);
            #1;
            dut_valid_i = 1'b1;
            dut_data_i  = r;
            exp_q.push_back(r);
            pushes++;
            @(posedge clk); #1;
            dut_valid_i = 1'b0;
            if (i == n - 1) begin
                @(negedge clk);
                chk("end_done", done_o, 1);
                chk("end_no_err", err_timeout_o, 0);
                @(negedge clk);
                chk("end_idle", busy_o, 0);
                chk("end_done_1cyc", done_o, 0);
            end
        end
    endtask

    task automatic drain();
        int k;
        rdy_en = 1'b1;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain_model_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("drain_res_valid", res_valid_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int hi;
        int k;
        int n;
        int sil;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {busy_o, done_o, err_timeout_o, res_valid_o, dut_req_o, smp_ready_o}, 0);
        chk("rst_data", {dut_data_o, res_data_o}, 0);

        // Single request with fixed values
        rdy_en = 1'b0;
        run_batch(1, -1, -1, 3, 'h5A, 'hA5);
        @(negedge clk);
        chk("single_res_valid", res_valid_o, 1);
        chk("single_res_data", res_data_o, 8'hA5);
        drain();

        // Zero-length batch
        run_batch(0, -1, -1, 0, -1, -1);

        // Engine valid outside WAIT must not push
        rdy_en = 1'b0;
        @(posedge clk); #1;
        dut_valid_i = 1'b1;
        dut_data_i  = 8'h33;
        @(posedge clk); #1;
        dut_valid_i = 1'b0;
        @(negedge clk);
        chk("idle_valid_ignored", res_valid_o, 0);

        // Backpressure: FIFO fills at DEPTH results, then drains in order
        rdy_en = 1'b0;
        fork
            run_batch(6, -1, -1, 1, -1, -1);
            begin
                for (k = 0; k < 2000; k++) begin
                    @(negedge clk);
                    if (exp_q.size() == DEPTH) break;
                end
                repeat (3) @(negedge clk);
                hi = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (smp_ready_o) hi++;
                end
                chk("bp_ready_low", hi, 0);
                chk("bp_res_valid", res_valid_o, 1);
                chk("bp_busy", busy_o, 1);
                rdy_en = 1'b1;
            end
        join
        drain();

        // Timeout on the first request: only one sample consumed
        c0 = consumed;
        run_batch(3, 0, -1, 0, -1, -1);
        chk("tmo_consumed", consumed - c0, 1);

        // Valid in the final WAIT cycle wins
        run_batch(2, -1, -1, 2, -1, -1);
        drain();

        // Reset while waiting with two results buffered
        rdy_en = 1'b0;
        run_batch(3, -1, 2, 1, -1, -1);
        chk("rst_err", err_timeout_o, 0);

        // Randomized batches
        rdy_en = 1'b1;
        for (int b = 0; b < 25; b++) begin
            n   = $urandom_range(0, 6);
            sil = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            run_batch(n, sil, -1, 0, -1, -1);
        end
        drain();

        chk("req_count", req_seen, req_exp);
`ifdef IFX_DIG_CMP_STATS_EN
        chk("res_cnt", res_cnt_o, pushes);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
